// File: rtl/tft_seq_pkg.sv
// Shared definitions for the TFT command sequencer: entry format, opcodes,
// default sequence ROM and the sequence offset table.
package tft_seq_pkg;

  localparam int unsigned ENTRY_W  = 10;
  localparam int unsigned ROM_MAX  = 64;
  localparam int unsigned ROM_AW   = 6;
  localparam int unsigned ROM_BITS = ROM_MAX * ENTRY_W;
  localparam int unsigned OFS_W    = 8;
  localparam int unsigned SEQ_MAX  = 16;

  typedef enum logic [1:0] {
    TyComm = 2'b00,
    TyData = 2'b01,
    TyWait = 2'b10,
    TyEnd  = 2'b11
  } entry_type_e;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  function automatic logic [ENTRY_W-1:0] ent(input entry_type_e ty, input logic [7:0] b);
    return {ty, b};
  endfunction

  // Init sequence at 0, full-screen (320x480) window at 16, display off at 32, on at 34.
  function automatic logic [ROM_BITS-1:0] build_rom();
    logic [ROM_BITS-1:0] r;
    r = {ROM_MAX{ent(TyEnd, 8'h00)}};
    r[0*ENTRY_W +: ENTRY_W]  = ent(TyComm, 8'h01);
    r[1*ENTRY_W +: ENTRY_W]  = ent(TyWait, 8'd150);
    r[2*ENTRY_W +: ENTRY_W]  = ent(TyComm, 8'h11);
    r[3*ENTRY_W +: ENTRY_W]  = ent(TyWait, 8'd120);
    r[4*ENTRY_W +: ENTRY_W]  = ent(TyComm, 8'h3A);
    r[5*ENTRY_W +: ENTRY_W]  = ent(TyData, 8'h55);
    r[6*ENTRY_W +: ENTRY_W]  = ent(TyComm, 8'h36);
    r[7*ENTRY_W +: ENTRY_W]  = ent(TyData, 8'h48);
    r[8*ENTRY_W +: ENTRY_W]  = ent(TyComm, 8'h29);
    r[16*ENTRY_W +: ENTRY_W] = ent(TyComm, CMD_CASET);
    r[17*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h00);
    r[18*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h00);
    r[19*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h01);
    r[20*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h3F);
    r[21*ENTRY_W +: ENTRY_W] = ent(TyComm, CMD_PASET);
    r[22*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h00);
    r[23*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h00);
    r[24*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h01);
    r[25*ENTRY_W +: ENTRY_W] = ent(TyData, 8'hDF);
    r[26*ENTRY_W +: ENTRY_W] = ent(TyComm, CMD_RAMWR);
    r[32*ENTRY_W +: ENTRY_W] = ent(TyComm, 8'h28);
    r[34*ENTRY_W +: ENTRY_W] = ent(TyComm, 8'h29);
    return r;
  endfunction

  localparam logic [ROM_BITS-1:0] ROM_DEFAULT = build_rom();

  // Entry i of the offset table lives in bits [i*OFS_W +: OFS_W].
  localparam logic [SEQ_MAX*OFS_W-1:0] SEQ_OFS_DEFAULT =
    {96'h0, 8'd34, 8'd32, 8'd16, 8'd0};

endpackage

// File: rtl/ms_timer.sv
// Millisecond down-counter: set loads ms*CLK_KHZ cycles, free when expired.
module ms_timer #(
  parameter int unsigned CLK_KHZ = 27000,
  parameter int unsigned MS_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set,
  input  logic [MS_W-1:0] ms,
  output logic            free
);

  localparam int unsigned MAX_CNT = ((1 << MS_W) - 1) * CLK_KHZ;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on set, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (set) begin
      cnt_d = CNT_W'(ms) * CNT_W'(CLK_KHZ);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign free = (cnt_q == '0);

endmodule

// File: rtl/tft_cmd_seq.sv
// TFT command sequencer: walks ROM entries (command/data/wait/end) and hands
// bytes to a byte transmitter. Optional window-set burst with TFT_SEQ_WINDOW_EN.
module tft_cmd_seq
  import tft_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned N_SEQ   = 4,
  parameter int unsigned CLK_KHZ = 27000,
  parameter int unsigned MS_W    = 8,
  parameter logic [ROM_BITS-1:0]    ROM     = ROM_DEFAULT,
  parameter logic [N_SEQ*OFS_W-1:0] SEQ_OFS = SEQ_OFS_DEFAULT[N_SEQ*OFS_W-1:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(N_SEQ)-1:0] seq_sel,
`ifdef TFT_SEQ_WINDOW_EN
  input  logic                     start_win,
  input  logic [15:0]              win_x0,
  input  logic [15:0]              win_x1,
  input  logic [15:0]              win_y0,
  input  logic [15:0]              win_y1,
`endif
  input  logic                     tft_busy,
  output logic                     tft_dc,
  output logic [7:0]               tft_data,
  output logic                     tft_transmit,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StIssue, StAck, StDelay, StFinish
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               tx_q, tx_d, dc_q, dc_d;
  logic [7:0]         data_q, data_d;
  logic [OFS_W-1:0]   seq_ofs;
  logic [ENTRY_W-1:0] cur_entry;
  logic [ROM_AW-1:0]  rom_addr;
  logic               at_end, advance, tmr_set, tmr_free;

`ifdef TFT_SEQ_WINDOW_EN
  localparam logic [3:0] WIN_LEN = 4'd11;
  logic               win_mode_q, win_mode_d;
  logic [3:0]         win_idx_q, win_idx_d;
  logic [15:0]        x0_q, x1_q, y0_q, y1_q;
  logic [ENTRY_W-1:0] win_entry;

  // Window burst entries generated from the captured bounds.
  always_comb begin
    case (win_idx_q)
      4'd0:    win_entry = ent(TyComm, CMD_CASET);
      4'd1:    win_entry = ent(TyData, x0_q[15:8]);
      4'd2:    win_entry = ent(TyData, x0_q[7:0]);
      4'd3:    win_entry = ent(TyData, x1_q[15:8]);
      4'd4:    win_entry = ent(TyData, x1_q[7:0]);
      4'd5:    win_entry = ent(TyComm, CMD_PASET);
      4'd6:    win_entry = ent(TyData, y0_q[15:8]);
      4'd7:    win_entry = ent(TyData, y0_q[7:0]);
      4'd8:    win_entry = ent(TyData, y1_q[15:8]);
      4'd9:    win_entry = ent(TyData, y1_q[7:0]);
      4'd10:   win_entry = ent(TyComm, CMD_RAMWR);
      default: win_entry = ent(TyEnd, 8'h00);
    endcase
  end

  // Capture window bounds when a burst is accepted; start has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else if (state_q == StIdle && start_win && !start) begin
      x0_q <= win_x0;
      x1_q <= win_x1;
      y0_q <= win_y0;
      y1_q <= win_y1;
    end
  end
`endif

  // Offset table lookup for the selected sequence.
  always_comb begin
    seq_ofs = '0;
    for (int unsigned i = 0; i < N_SEQ; i++) begin
      if (32'(seq_sel) == i) seq_ofs = SEQ_OFS[i*OFS_W +: OFS_W];
    end
  end

  // Current entry and end-of-source detection (ROM never wraps past DEPTH).
  always_comb begin
    rom_addr  = ROM_AW'(index_q);
    cur_entry = ROM[rom_addr*ENTRY_W +: ENTRY_W];
    at_end    = (index_q >= IDX_W'(DEPTH));
`ifdef TFT_SEQ_WINDOW_EN
    if (win_mode_q) begin
      cur_entry = win_entry;
      at_end    = (win_idx_q == WIN_LEN);
    end
`endif
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    tx_d    = 1'b0;
    dc_d    = dc_q;
    data_d  = data_q;
    tmr_set = 1'b0;
    advance = 1'b0;
`ifdef TFT_SEQ_WINDOW_EN
    win_mode_d = win_mode_q;
    win_idx_d  = win_idx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          index_d = IDX_W'(seq_ofs);
          state_d = StFetch;
`ifdef TFT_SEQ_WINDOW_EN
          win_mode_d = 1'b0;
        end else if (start_win) begin
          win_mode_d = 1'b1;
          win_idx_d  = '0;
          state_d    = StFetch;
`endif
        end
      end
      StFetch: begin
        if (at_end) begin
          state_d = StFinish;
        end else begin
          unique case (entry_type_e'(cur_entry[9:8]))
            TyComm, TyData: state_d = StIssue;
            TyWait: begin
              tmr_set = 1'b1;
              state_d = StDelay;
            end
            TyEnd: state_d = StFinish;
          endcase
        end
      end
      StIssue: begin
        if (!tft_busy) begin
          tx_d    = 1'b1;
          dc_d    = cur_entry[8];
          data_d  = cur_entry[7:0];
          state_d = StAck;
        end
      end
      // The strobe cycle is skipped so the transmitter gets to raise its busy.
      StAck: begin
        if (!tx_q && !tft_busy) begin
          advance = 1'b1;
          state_d = StFetch;
        end
      end
      StDelay: begin
        if (tmr_free) begin
          advance = 1'b1;
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (advance) begin
`ifdef TFT_SEQ_WINDOW_EN
      if (win_mode_q) win_idx_d = win_idx_q + 4'd1;
      else            index_d   = index_q + 1'b1;
`else
      index_d = index_q + 1'b1;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      index_q <= '0;
      tx_q    <= 1'b0;
      dc_q    <= 1'b0;
      data_q  <= 8'h00;
`ifdef TFT_SEQ_WINDOW_EN
      win_mode_q <= 1'b0;
      win_idx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tx_q    <= tx_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
`ifdef TFT_SEQ_WINDOW_EN
      win_mode_q <= win_mode_d;
      win_idx_q  <= win_idx_d;
`endif
    end
  end

  ms_timer #(
    .CLK_KHZ (CLK_KHZ),
    .MS_W    (MS_W)
  ) u_ms_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (tmr_set),
    .ms    (cur_entry[MS_W-1:0]),
    .free  (tmr_free)
  );

  assign tft_transmit = tx_q;
  assign tft_dc       = dc_q;
  assign tft_data     = data_q;
  assign busy         = (state_q != StIdle) && (state_q != StFinish);
  assign done         = (state_q == StFinish);

endmodule

// File: tb/tb_tft_cmd_seq.sv
// Directed bench for tft_cmd_seq; window-burst tests need TFT_SEQ_WINDOW_EN.
module tb_tft_cmd_seq;
  import tft_seq_pkg::*;

  function automatic logic [ROM_BITS-1:0] mk_rom_a();
    logic [ROM_BITS-1:0] r;
    r = {ROM_MAX{ent(TyEnd, 8'h00)}};
    r[0*ENTRY_W +: ENTRY_W] = ent(TyComm, 8'hC0);
    r[1*ENTRY_W +: ENTRY_W] = ent(TyData, 8'h17);
    r[2*ENTRY_W +: ENTRY_W] = ent(TyWait, 8'h02);
    r[3*ENTRY_W +: ENTRY_W] = ent(TyComm, 8'h29);
    r[8*ENTRY_W +: ENTRY_W] = ent(TyComm, 8'h11);
    r[9*ENTRY_W +: ENTRY_W] = ent(TyWait, 8'd200);
    r[10*ENTRY_W +: ENTRY_W] = ent(TyComm, 8'h29);
    return r;
  endfunction

  function automatic logic [ROM_BITS-1:0] mk_rom_b();
    logic [ROM_BITS-1:0] r;
    r = {ROM_MAX{ent(TyEnd, 8'h00)}};
    for (int i = 0; i < 8; i++) begin
      r[i*ENTRY_W +: ENTRY_W] = ent((i % 2 == 1) ? TyData : TyComm, 8'(8'h10 + i));
    end
    r[8*ENTRY_W +: ENTRY_W] = ent(TyData, 8'hAA);
    return r;
  endfunction

  localparam logic [ROM_BITS-1:0] ROM_A = mk_rom_a();
  localparam logic [ROM_BITS-1:0] ROM_B = mk_rom_b();

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic seq_sel_a, seq_sel_b;
  logic busy_in_a, busy_in_b, hold_a;
  logic dc_a, dc_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] data_a, data_b;
`ifdef TFT_SEQ_WINDOW_EN
  logic start_win_a;
  logic [15:0] x0, x1, y0, y1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tft_cmd_seq #(
    .DEPTH   (64),
    .N_SEQ   (2),
    .CLK_KHZ (10),
    .MS_W    (8),
    .ROM     (ROM_A),
    .SEQ_OFS ({8'd8, 8'd0})
  ) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_a),
    .seq_sel      (seq_sel_a),
`ifdef TFT_SEQ_WINDOW_EN
    .start_win    (start_win_a),
    .win_x0       (x0),
    .win_x1       (x1),
    .win_y0       (y0),
    .win_y1       (y1),
`endif
    .tft_busy     (busy_in_a),
    .tft_dc       (dc_a),
    .tft_data     (data_a),
    .tft_transmit (tx_a),
    .busy         (busy_a),
    .done         (done_a)
  );

  tft_cmd_seq #(
    .DEPTH   (8),
    .N_SEQ   (2),
    .CLK_KHZ (10),
    .MS_W    (8),
    .ROM     (ROM_B),
    .SEQ_OFS (16'h0000)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_b),
    .seq_sel      (seq_sel_b),
`ifdef TFT_SEQ_WINDOW_EN
    .start_win    (1'b0),
    .win_x0       (16'h0000),
    .win_x1       (16'h0000),
    .win_y0       (16'h0000),
    .win_y1       (16'h0000),
`endif
    .tft_busy     (busy_in_b),
    .tft_dc       (dc_b),
    .tft_data     (data_b),
    .tft_transmit (tx_b),
    .busy         (busy_b),
    .done         (done_b)
  );

  // Transmitter models: 3 busy cycles after each strobe; hold_a stretches A.
  int cnt_a = 0;
  int cnt_b = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      cnt_a <= tx_a ? 3 : ((cnt_a != 0) ? cnt_a - 1 : 0);
      cnt_b <= tx_b ? 3 : ((cnt_b != 0) ? cnt_b - 1 : 0);
    end
  end
  assign busy_in_a = (cnt_a != 0) || hold_a;
  assign busy_in_b = (cnt_b != 0);

  // Strobe / done recorders.
  int cyc = 0;
  logic [8:0] sa_v [256];
  int sa_c [256];
  int sa_n = 0;
  int da_n = 0;
  int da_last = 0;
  int dup_a = 0;
  bit tx_a_prev = 1'b0;
  logic [8:0] sb_v [256];
  int sb_n = 0;
  int db_n = 0;
  int dup_b = 0;
  bit tx_b_prev = 1'b0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    tx_a_prev <= tx_a;
    tx_b_prev <= tx_b;
    if (tx_a) begin
      sa_v[sa_n % 256] <= {dc_a, data_a};
      sa_c[sa_n % 256] <= cyc;
      sa_n <= sa_n + 1;
      if (tx_a_prev) dup_a <= dup_a + 1;
    end
    if (done_a) begin
      da_n    <= da_n + 1;
      da_last <= cyc;
    end
    if (tx_b) begin
      sb_v[sb_n % 256] <= {dc_b, data_b};
      sb_n <= sb_n + 1;
      if (tx_b_prev) dup_b <= dup_b + 1;
    end
    if (done_b) db_n <= db_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic sel);
    seq_sel_a = sel;
    start_a   = 1'b1;
    step();
    start_a   = 1'b0;
  endtask

  task automatic wait_done_a(input int dbase, input int budget, input string tag);
    int n = 0;
    while (da_n == dbase && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(da_n != dbase), 1);
  endtask

  task automatic wait_strobe_a(input int sbase, input int budget, input string tag);
    int n = 0;
    while (sa_n == sbase && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(sa_n != sbase), 1);
  endtask

  int base, dbase, rel, n;
`ifdef TFT_SEQ_WINDOW_EN
  logic [8:0] exp_win [11];
`endif

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; seq_sel_a = 1'b0; seq_sel_b = 1'b0; hold_a = 1'b0;
`ifdef TFT_SEQ_WINDOW_EN
    start_win_a = 1'b0; x0 = 16'd0; x1 = 16'd0; y0 = 16'd0; y1 = 16'd0;
`endif
    repeat (3) step();
    chk("rst_tx", 32'(tx_a), 0);
    chk("rst_dc", 32'(dc_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    rst_n = 1'b1;
    step();

    // Test 1: basic ROM sequence with a 2 ms wait at 10 kHz.
    base = sa_n; dbase = da_n;
    pulse_a(1'b0);
    chk("t1_busy_rise", 32'(busy_a), 1);
    wait_done_a(dbase, 500, "t1_done_timeout");
    chk("t1_busy_drop", 32'(busy_a), 0);
    chk("t1_count", 32'(sa_n - base), 3);
    chk("t1_s0", 32'(sa_v[base]), {23'd0, 1'b0, 8'hC0});
    chk("t1_s1", 32'(sa_v[base+1]), {23'd0, 1'b1, 8'h17});
    chk("t1_s2", 32'(sa_v[base+2]), {23'd0, 1'b0, 8'h29});
    chk("t1_gap", 32'((sa_c[base+2] - sa_c[base+1]) >= 20), 1);
    chk("t1_done_after_ack", 32'(da_last > sa_c[base+2] + 3), 1);

    // Test 2: transmitter held busy for 50 cycles after the first strobe.
    base = sa_n; dbase = da_n;
    pulse_a(1'b0);
    wait_strobe_a(base, 100, "t2_first_timeout");
    hold_a = 1'b1;
    repeat (50) step();
    chk("t2_held", 32'(sa_n - base), 1);
    rel = cyc;
    hold_a = 1'b0;
    wait_done_a(dbase, 500, "t2_done_timeout");
    chk("t2_count", 32'(sa_n - base), 3);
    chk("t2_no_early", 32'(sa_c[base+1] >= rel), 1);
    chk("t2_s1", 32'(sa_v[base+1]), {23'd0, 1'b1, 8'h17});
    chk("t2_single_cycle", 32'(dup_a), 0);

`ifdef TFT_SEQ_WINDOW_EN
    // Test 3: window burst.
    exp_win = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
                9'h02B, 9'h100, 9'h100, 9'h101, 9'h1DF, 9'h02C};
    base = sa_n; dbase = da_n;
    x0 = 16'd0; x1 = 16'd319; y0 = 16'd0; y1 = 16'd479;
    start_win_a = 1'b1;
    step();
    start_win_a = 1'b0;
    wait_done_a(dbase, 400, "t3_done_timeout");
    chk("t3_count", 32'(sa_n - base), 11);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t3_b%0d", i), 32'(sa_v[base+i]), 32'(exp_win[i]));
    end
`endif

    // Test 4: start beats start_win; start while busy is ignored.
    base = sa_n; dbase = da_n;
    seq_sel_a = 1'b0;
    start_a = 1'b1;
`ifdef TFT_SEQ_WINDOW_EN
    start_win_a = 1'b1;
`endif
    step();
    start_a = 1'b0;
`ifdef TFT_SEQ_WINDOW_EN
    start_win_a = 1'b0;
`endif
    repeat (5) step();
    start_a = 1'b1;
`ifdef TFT_SEQ_WINDOW_EN
    start_win_a = 1'b1;
`endif
    step();
    start_a = 1'b0;
`ifdef TFT_SEQ_WINDOW_EN
    start_win_a = 1'b0;
`endif
    wait_done_a(dbase, 500, "t4_done_timeout");
    repeat (100) step();
    chk("t4_count", 32'(sa_n - base), 3);
    chk("t4_s0", 32'(sa_v[base]), {23'd0, 1'b0, 8'hC0});
    chk("t4_one_done", 32'(da_n - dbase), 1);

    // Test 5: reset during a 200 ms wait, then rerun from the first entry.
    base = sa_n;
    pulse_a(1'b1);
    wait_strobe_a(base, 100, "t5_first_timeout");
    repeat (100) step();
    chk("t5_in_delay", 32'(busy_a), 1);
    dbase = da_n;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(tx_a), 0);
    chk("t5_rst_dc", 32'(dc_a), 0);
    chk("t5_rst_data", 32'(data_a), 0);
    chk("t5_rst_busy", 32'(busy_a), 0);
    chk("t5_rst_done", 32'(done_a), 0);
    step();
    rst_n = 1'b1;
    base = sa_n;
    pulse_a(1'b1);
    chk("t5_accept_first", 32'(busy_a), 1);
    chk("t5_no_done", 32'(da_n - dbase), 0);
    wait_done_a(dbase, 3000, "t5_done_timeout");
    chk("t5_count", 32'(sa_n - base), 2);
    chk("t5_s0", 32'(sa_v[base]), {23'd0, 1'b0, 8'h11});
    chk("t5_s1", 32'(sa_v[base+1]), {23'd0, 1'b0, 8'h29});
    chk("t5_gap", 32'((sa_c[base+1] - sa_c[base]) >= 2000), 1);

    // Test 6: no END entry with DEPTH=8 stops after 8 entries.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    while (db_n == 0 && n < 400) begin
      step();
      n++;
    end
    chk("t6_done_timeout", 32'(db_n != 0), 1);
    repeat (50) step();
    chk("t6_count", 32'(sb_n), 8);
    chk("t6_one_done", 32'(db_n), 1);
    chk("t6_single_cycle", 32'(dup_b), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_e%0d", i), 32'(sb_v[i]), 32'({i[0], 8'(8'h10 + i)}));
    end
    chk("t6_idle", 32'(busy_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tft_cmd_seq.md
TFT_CMD_SEQ -- requirements
Module: tft_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 64: number of entries in the sequence ROM.
REQ-002 Parameter N_SEQ, default 4: number of selectable sequences.
REQ-003 Parameter CLK_KHZ, default 27000: clk cycles per millisecond.
REQ-004 Parameter MS_W, default 8: width of the WAIT millisecond field (fixed at 8 by the entry format).
REQ-005 Port clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port start  in  1  one-cycle request to run the sequence selected by seq_sel.
REQ-008 Port seq_sel  in  $clog2(N_SEQ)  sequence index; sampled only on an accepted start.
REQ-009 Port start_win  in  1  one-cycle request to emit the window-set burst (TFT_SEQ_WINDOW_EN only).
REQ-010 Ports win_x0, win_x1, win_y0, win_y1  in  16 each  window bounds; sampled on an accepted start_win (TFT_SEQ_WINDOW_EN only).
REQ-011 Port tft_busy  in  1  byte transmitter is busy.
REQ-012 Port tft_dc  out  1  0 = command byte, 1 = data byte.
REQ-013 Port tft_data  out  8  byte to transmit.
REQ-014 Port tft_transmit  out  1  one-cycle strobe that hands tft_dc/tft_data to the transmitter.
REQ-015 Port busy  out  1  high from the cycle after an accepted request until done.
REQ-016 Port done  out  1  one-cycle pulse on completion.

Function
REQ-017 Each entry SHALL be 10 bits {type[1:0], byte[7:0]}, with type COMM=00, DATA=01, WAIT=10, END=11.
REQ-018 A start accepted in IDLE SHALL load the index from the sequence offset table at seq_sel; busy SHALL rise the next cycle.
REQ-019 The FSM SHALL have the states IDLE, FETCH, ISSUE, ACK, DELAY, FINISH.
REQ-020 FETCH SHALL decode the entry: COMM/DATA -> ISSUE; WAIT -> DELAY; END -> FINISH.
REQ-021 ISSUE SHALL wait for tft_busy=0, then assert tft_transmit for exactly 1 cycle, with tft_dc=type[0] and tft_data=byte held stable until the next ISSUE.
REQ-022 ACK SHALL last at least 1 cycle and SHALL return to FETCH with index+1 only once tft_busy=0; tft_transmit is never asserted on consecutive cycles.
REQ-023 DELAY SHALL wait byte*CLK_KHZ cycles (±1), then go to FETCH with index+1; byte=0 SHALL give a 1-cycle DELAY.
REQ-024 If index reaches DEPTH without an END entry, the FSM SHALL go to FINISH (no wrap-around).
REQ-025 FINISH SHALL pulse done for 1 cycle, drop busy in the same cycle, and return to IDLE.
REQ-026 start or start_win while busy SHALL be ignored, with no queuing.
REQ-027 If start and start_win arrive in the same cycle, start SHALL win and start_win SHALL be dropped.
REQ-028 An accepted start_win SHALL emit 11 bytes in this order: C 2A, D x0[15:8], D x0[7:0], D x1[15:8], D x1[7:0], C 2B, D y0 hi, D y0 lo, D y1 hi, D y1 lo, C 2C; it SHALL then go to FINISH.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, index=0, delay counter=0, tft_transmit=0, tft_dc=0, tft_data=8'h00, busy=0, done=0.
REQ-030 Reset mid-sequence or mid-delay SHALL abort without a done pulse; after release the block SHALL be idle and SHALL accept start in the first cycle.

Configuration
REQ-031 With macro TFT_SEQ_WINDOW_EN defined, start_win and win_* SHALL exist and REQ-028 SHALL apply.
REQ-032 Without TFT_SEQ_WINDOW_EN, those ports and the burst logic SHALL be absent, and only ROM sequences SHALL run.

Structure
REQ-033 Package tft_seq_pkg SHALL hold the entry type codes, the entry width, the ROM contents (init sequence and full-screen window sequence), the sequence offset table, and the CASET/PASET/RAMWR opcodes.
REQ-034 The millisecond delay SHALL be a sub-module ms_timer (inputs set and ms[7:0], output free, parameter CLK_KHZ).

Verification
REQ-035 Test 1, CLK_KHZ=10, transmitter model with 3-cycle busy, start with seq_sel=0 on a ROM of {C C0, D 17, W 02, C 29, END}:
- 3 strobes with dc/data 0/C0, 1/17, 0/29.
- A gap of at least 20 cycles before C 29.
- done after the last ACK.
REQ-036 Test 2, tft_busy held high 50 cycles after the first strobe: no second strobe until tft_busy=0; each strobe exactly 1 cycle.
REQ-037 Test 3, start_win with x0=0, x1=319, y0=0, y1=479: bytes 2A 00 00 01 3F 2B 00 00 01 DF 2C, with dc 0,1,1,1,1,0,1,1,1,1,0.
REQ-038 Test 4, start and start_win in the same cycle, then start pulsed while busy: only the ROM sequence runs, once, with exactly one done.
REQ-039 Test 5, rst_n asserted during a WAIT of 200 ms: all outputs are 0 immediately, with no done; a new start runs the full sequence from its first entry.
REQ-040 Test 6, ROM with no END and DEPTH=8: 8 entries are issued, then done; index does not wrap.
